avr_prefetch: RTL and testbench
===============================

Name: avr_prefetch

Overview:
- Parametrised successor to the single-register fetch stage: a DEPTH-entry instruction prefetch queue between program memory and the core decoder.
- Streams sequential program words ahead of the core and presents one instruction per handshake.
- Recognises 32-bit AVR instructions (JMP, CALL, LDS, STS) and presents both words together.
- Flushes and restarts on a core redirect, replacing the PC hold/+1/+2/jump mux.

Parameters:
- ADDR_W, 16, program word address width; PCs wrap modulo 2^ADDR_W.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low; released synchronously by the integrator.
- prog_addr  out  ADDR_W  program memory word address.
- prog_req  out  1  read request; memory returns prog_data on the following cycle (fixed latency 1).
- prog_data  in  16  raw memory word; bytes are swapped on capture, so queue word = {prog_data[7:0], prog_data[15:8]}.
- redirect  in  1  taken branch/jump/ret: flush and restart.
- redirect_pc  in  ADDR_W  restart address, sampled when redirect=1.
- instr  out  16  head instruction word (swapped).
- instr_ext  out  16  second word when instr_long=1, else 0.
- instr_pc  out  ADDR_W  address of instr.
- instr_long  out  1  head is a 32-bit instruction.
- instr_valid  out  1  head available (both words present if long).
- instr_ready  in  1  core accepts head; pop occurs when instr_valid & instr_ready.

Behaviour:
- Reset (RST_N=0, any time, including mid-flush or with a request in flight):
  - queue empty; in-flight tag cleared.
  - fetch_pc=RESET_PC; prog_req=0, prog_addr=RESET_PC.
  - instr=0, instr_ext=0, instr_pc=0, instr_long=0, instr_valid=0.
- State: circular queue of {pc, word}, rd/wr pointers (log2 DEPTH), count (log2 DEPTH + 1), inflight flag, fetch_pc.
- Issue:
  - prog_req=1 when count + inflight < DEPTH; conservative, no credit for a same-cycle pop.
  - prog_addr=fetch_pc; on issue, fetch_pc <= fetch_pc+1 and inflight <= 1.
- Capture: when inflight=1 and no redirect this cycle, the swapped prog_data is written at wr_ptr with its request PC; count+1.
- Long decode on the head word w:
  - long when w[15:9]=1001010 and w[3:2]=11 (JMP/CALL), or w[15:10]=100100 and w[3:0]=0000 (LDS/STS).
  - long head: instr_valid only when count >= 2; instr_ext = entry at rd_ptr+1.
  - long head with DEPTH=2 completes normally.
  - wrap: long instr at PC 2^ADDR_W-1 takes its ext word from PC 0.
- Pop: pops 1 entry (short) or 2 entries (long); rd_ptr and count update on the same edge. A simultaneous capture and pop are both applied.
- Outputs: instr/instr_pc/instr_ext/instr_long are combinational from the head entry; they are 0 when the queue is empty. No forwarding from prog_data to the outputs (except under the optional feature).
- Redirect (priority over pop and capture):
  - same cycle: prog_addr=redirect_pc, prog_req=1, instr_valid forced 0.
  - at the edge: queue emptied, the prior in-flight response is discarded, fetch_pc <= redirect_pc+1, inflight <= 1.
  - latency: redirect in cycle N → word captured at end of N+1 → instr_valid in N+2.
- Back-to-back redirects: each restarts; only the latest request's data is captured.
- Full queue with instr_ready=0: no requests; the head is held stable.

Optional Feature:
- Macro: AVR_PREFETCH_BYPASS_EN.
- Defined:
  - when the queue is empty, inflight=1, there is no redirect, and the returning word is short, that word drives instr/instr_pc with instr_valid=1 in the same cycle.
  - if popped that cycle, it is not written to the queue; otherwise it is written normally.
  - redirect-to-valid latency becomes N+1.
- Undefined: no bypass; latency N+2 as above.

Test Plan:
- Reset then release, memory holds 0x0000 at 0..7, instr_ready=1 → requests to 0,1,2,...; first instr_valid 2 cycles after the first prog_req; instr_pc increments by 1 per cycle.
- instr_ready=0 with DEPTH=4 → exactly 4 requests, then prog_req=0; instr_pc stays 0 until ready.
- Memory word at PC 5 = 0x0C94 (swapped JMP 0x940C), PC 6 = ext → single pop with instr_long=1, instr=0x940C, instr_ext=swapped word 6, next instr_pc=7.
- Redirect to 0x0100 while the queue holds 3 entries and a request is in flight → stale data never appears; next valid instr_pc=0x0100 at N+2 (N+1 with AVR_PREFETCH_BYPASS_EN).
- Long instruction at PC 0xFFFF (ADDR_W=16) → instr_ext taken from PC 0; next instr_pc=0x0001.
- RST_N pulsed low mid-stream with inflight=1 → all outputs 0 immediately (asynchronous); first request after release is at RESET_PC.

Source files
------------

// File: rtl/avr_prefetch.sv
// DEPTH-entry AVR instruction prefetch queue with 32-bit instruction pairing and redirect flush.
// Optional same-cycle bypass of a returning word into an empty queue: define AVR_PREFETCH_BYPASS_EN.
module avr_prefetch #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_req,
  input  logic [15:0]       prog_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       instr,
  output logic [15:0]       instr_ext,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_long,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int PW = $clog2(DEPTH);

  logic [15:0]       ent_word_q [DEPTH];
  logic [ADDR_W-1:0] ent_pc_q   [DEPTH];

  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;

  logic [15:0]       cap_word;
  logic [PW-1:0]     rd_nxt;
  logic [15:0]       head_w;
  logic              head_long;
  logic [PW+1:0]     occ;
  logic              issue;
  logic              byp;
  logic              pop;
  logic [1:0]        pop_n;
  logic [1:0]        deq_n;
  logic              cap_wr;

  function automatic logic is_long(input logic [15:0] w);
    return ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11)) ||
           ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000));
  endfunction

  always_comb begin
    cap_word  = {prog_data[7:0], prog_data[15:8]};
    rd_nxt    = rd_q + PW'(1);
    head_w    = ent_word_q[rd_q];
    head_long = is_long(head_w);

    instr       = '0;
    instr_ext   = '0;
    instr_pc    = '0;
    instr_long  = 1'b0;
    instr_valid = 1'b0;
    byp         = 1'b0;
    if (cnt_q != '0) begin
      instr       = head_w;
      instr_pc    = ent_pc_q[rd_q];
      instr_long  = head_long;
      instr_valid = !redirect && (!head_long || (cnt_q >= (PW+1)'(2)));
      if (head_long && (cnt_q >= (PW+1)'(2)))
        instr_ext = ent_word_q[rd_nxt];
    end
`ifdef AVR_PREFETCH_BYPASS_EN
    else if (infl_q && !redirect && !is_long(cap_word)) begin
      byp         = 1'b1;
      instr       = cap_word;
      instr_pc    = rpc_q;
      instr_valid = 1'b1;
    end
`endif

    pop   = instr_valid && instr_ready;
    pop_n = pop ? (instr_long ? 2'd2 : 2'd1) : 2'd0;
    // A bypassed word that is consumed never enters the queue, so nothing dequeues either.
    deq_n = byp ? 2'd0 : pop_n;

    occ       = {1'b0, cnt_q} + {{(PW+1){1'b0}}, infl_q};
    issue     = redirect || (occ < (PW+2)'(DEPTH));
    prog_req  = RST_N && issue;
    prog_addr = !RST_N ? RESET_PC : (redirect ? redirect_pc : fpc_q);

    cap_wr = infl_q && !redirect && !(byp && pop);

    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    infl_d = infl_q;
    fpc_d  = fpc_q;
    rpc_d  = rpc_q;
    if (redirect) begin
      rd_d   = wr_q;
      cnt_d  = '0;
      infl_d = 1'b1;
      fpc_d  = redirect_pc + ADDR_W'(1);
      rpc_d  = redirect_pc;
    end else begin
      infl_d = issue;
      if (issue) begin
        fpc_d = fpc_q + ADDR_W'(1);
        rpc_d = fpc_q;
      end
      if (cap_wr)
        wr_d = wr_q + PW'(1);
      rd_d  = rd_q + PW'(deq_n);
      cnt_d = cnt_q + (PW+1)'(cap_wr) - (PW+1)'(deq_n);
    end
  end

  always_ff @(posedge CLK) begin
    if (cap_wr) begin
      ent_word_q[wr_q] <= cap_word;
      ent_pc_q[wr_q]   <= rpc_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      infl_q <= 1'b0;
      fpc_q  <= RESET_PC;
      rpc_q  <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      fpc_q  <= fpc_d;
      rpc_q  <= rpc_d;
    end
  end

endmodule

// File: tb/tb_avr_prefetch.sv
// Scoreboard bench for avr_prefetch: expected instruction stream is built from the memory image.
module tb_avr_prefetch;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef AVR_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] prog_addr;
  logic        prog_req;
  logic [15:0] prog_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_ext;
  logic [15:0] instr_pc;
  logic        instr_long;
  logic        instr_valid;
  logic        instr_ready;

  avr_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .prog_addr(prog_addr), .prog_req(prog_req), .prog_data(prog_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_ext(instr_ext), .instr_pc(instr_pc),
    .instr_long(instr_long), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [0:65535];
  always @(posedge CLK) begin
    if (prog_req) prog_data <= mem[prog_addr];
  end

  typedef struct {
    logic [15:0] pc;
    logic [15:0] w;
    logic [15:0] ext;
    logic        lng;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   nreq  = 0;

  function automatic logic [15:0] swap(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  function automatic logic model_long(input logic [15:0] w);
    return (w[15:9] == 7'b1001010 && w[3:2] == 2'b11) || (w[15:10] == 6'b100100 && w[3:0] == 4'b0000);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_load(input logic [15:0] start, input int n);
    logic [15:0] p;
    exp_t e;
    sbq.delete();
    p = start;
    for (int i = 0; i < n; i++) begin
      e.pc  = p;
      e.w   = swap(mem[p]);
      e.lng = model_long(e.w);
      e.ext = e.lng ? swap(mem[p + 16'd1]) : 16'h0000;
      sbq.push_back(e);
      p = p + (e.lng ? 16'd2 : 16'd1);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step();
    exp_t e;
    if (instr_valid && instr_ready) begin
      if (sbq.size() == 0) begin
        check_eq("sb_empty", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        check_eq("sb_pc",   32'(instr_pc),   32'(e.pc));
        check_eq("sb_instr", 32'(instr),     32'(e.w));
        check_eq("sb_long", 32'(instr_long), 32'(e.lng));
        check_eq("sb_ext",  32'(instr_ext),  32'(e.ext));
      end
    end
    if (prog_req) nreq++;
    @(negedge CLK);
  endtask

  task automatic tick();
    settle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = swap({4'h1, 12'(i)});
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    RST_N = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    repeat (2) @(negedge CLK);

    settle();
    check_eq("rst_req",   32'(prog_req),    32'd0);
    check_eq("rst_addr",  32'(prog_addr),   32'(RESET_PC));
    check_eq("rst_instr", 32'(instr),       32'd0);
    check_eq("rst_ext",   32'(instr_ext),   32'd0);
    check_eq("rst_pc",    32'(instr_pc),    32'd0);
    check_eq("rst_long",  32'(instr_long),  32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    @(negedge CLK);

    // Sequential stream from reset
    sb_load(RESET_PC, 64);
    RST_N = 1'b1;
    settle();
    check_eq("first_req",  32'(prog_req),  32'd1);
    check_eq("first_addr", 32'(prog_addr), 32'(RESET_PC));
    step();
    settle();
    check_eq("n1_valid", 32'(instr_valid), 32'(BYP));
    check_eq("n1_addr",  32'(prog_addr),   32'd1);
    step();
    settle();
    check_eq("n2_valid", 32'(instr_valid), 32'd1);
    check_eq("n2_pc",    32'(instr_pc),    BYP ? 32'd1 : 32'd0);
    step();
    repeat (10) begin
      settle();
      check_eq("stream_valid", 32'(instr_valid), 32'd1);
      step();
    end

    // Full queue with the core stalled, then drain through a JMP at PC 5
    mem[5] = 16'h0C94;
    mem[6] = 16'h1234;
    redirect = 1'b1; redirect_pc = 16'h0000; instr_ready = 1'b0;
    sb_load(16'h0000, 64);
    nreq = 0;
    settle();
    check_eq("redir_req",   32'(prog_req),    32'd1);
    check_eq("redir_valid", 32'(instr_valid), 32'd0);
    step();
    redirect = 1'b0;
    repeat (9) begin
      settle();
      check_eq("hold_pc", 32'(instr_pc), 32'd0);
      step();
    end
    check_eq("full_reqs", 32'(nreq), 32'd4);
    settle();
    check_eq("full_req",   32'(prog_req),    32'd0);
    check_eq("full_valid", 32'(instr_valid), 32'd1);
    step();
    instr_ready = 1'b1;
    repeat (14) tick();

    // Long head waits for its second word
    redirect = 1'b1; redirect_pc = 16'h0005;
    sb_load(16'h0005, 64);
    tick();
    redirect = 1'b0;
    tick();
    settle();
    check_eq("long_half_valid", 32'(instr_valid), 32'd0);
    check_eq("long_half_long",  32'(instr_long),  32'd1);
    step();
    settle();
    check_eq("long_valid", 32'(instr_valid), 32'd1);
    check_eq("long_instr", 32'(instr),       32'h940C);
    check_eq("long_ext",   32'(instr_ext),   32'h3412);
    step();
    settle();
    check_eq("after_long_pc", 32'(instr_pc), 32'd7);
    step();
    repeat (4) tick();

    // Redirect while 3 entries are queued and a request is in flight
    redirect = 1'b1; redirect_pc = 16'h0040; instr_ready = 1'b0;
    sb_load(16'h0040, 64);
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 16'h0100; instr_ready = 1'b1;
    sb_load(16'h0100, 64);
    settle();
    check_eq("flush_addr",  32'(prog_addr),   32'h0100);
    check_eq("flush_req",   32'(prog_req),    32'd1);
    check_eq("flush_valid", 32'(instr_valid), 32'd0);
    step();
    redirect = 1'b0;
    settle();
    check_eq("flush_n1_valid", 32'(instr_valid), 32'(BYP));
    step();
    settle();
    check_eq("flush_n2_valid", 32'(instr_valid), 32'd1);
    check_eq("flush_n2_pc",    32'(instr_pc),    BYP ? 32'h0101 : 32'h0100);
    step();
    repeat (8) tick();

    // Long instruction at the top of the address space
    mem[16'hFFFF] = 16'h0C94;
    mem[16'h0000] = 16'h5678;
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    sb_load(16'hFFFF, 64);
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    settle();
    check_eq("wrap_pc",  32'(instr_pc),  32'h0001);
    check_eq("wrap_req", 32'(prog_req),  32'd1);
    step();
    repeat (4) tick();

    // Asynchronous reset in mid-stream
    settle();
    check_eq("pre_rst_valid", 32'(instr_valid), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    check_eq("arst_req",   32'(prog_req),    32'd0);
    check_eq("arst_addr",  32'(prog_addr),   32'(RESET_PC));
    check_eq("arst_valid", 32'(instr_valid), 32'd0);
    check_eq("arst_instr", 32'(instr),       32'd0);
    check_eq("arst_pc",    32'(instr_pc),    32'd0);
    check_eq("arst_long",  32'(instr_long),  32'd0);
    check_eq("arst_ext",   32'(instr_ext),   32'd0);
    repeat (2) @(negedge CLK);
    sb_load(RESET_PC, 64);
    RST_N = 1'b1;
    settle();
    check_eq("rel_req",  32'(prog_req),  32'd1);
    check_eq("rel_addr", 32'(prog_addr), 32'(RESET_PC));
    step();
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
